// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - pending-destination scoreboard for the dual-issue stage (optional SCOREBOARD_WATCHDOG_EN)
module issue_scoreboard #(
    parameter int NREG = 32
`ifdef SCOREBOARD_WATCHDOG_EN
    ,
    parameter int AGE_W = 6
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       stall,
    input  logic [4:0] q0_rj,
    input  logic [4:0] q0_rk,
    input  logic [4:0] q0_rd,
    input  logic       q0_rd_src,
    input  logic       q0_we,
    input  logic [4:0] q1_rj,
    input  logic [4:0] q1_rk,
    input  logic [4:0] q1_rd,
    input  logic       q1_rd_src,
    input  logic       q1_we,
    output logic       hazard0,
    output logic       hazard1,
    input  logic       iss0_go,
    input  logic [4:0] iss0_rd,
    input  logic       iss0_long,
    input  logic       iss1_go,
    input  logic [4:0] iss1_rd,
    input  logic       iss1_long,
    input  logic       wb0_valid,
    input  logic [4:0] wb0_rd,
    input  logic       wb1_valid,
    input  logic [4:0] wb1_rd,
    output logic [5:0] pend_cnt,
    output logic       wb_orphan,
    output logic       wd_timeout
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] pend_nxt;
    logic            orphan_hit;
    logic [5:0]      cnt_nxt;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss0_go && iss0_long && iss0_rd != 5'd0 && !stall) set_mask[iss0_rd] = 1'b1;
        if (iss1_go && iss1_long && iss1_rd != 5'd0 && !stall) set_mask[iss1_rd] = 1'b1;
        if (wb0_valid && wb0_rd != 5'd0) clr_mask[wb0_rd] = 1'b1;
        if (wb1_valid && wb1_rd != 5'd0) clr_mask[wb1_rd] = 1'b1;

        // set wins over clear so a same-cycle issue/writeback of one rd stays pending
        pend_nxt    = flush ? '0 : ((pending & ~clr_mask) | set_mask);
        pend_nxt[0] = 1'b0;

        orphan_hit = !flush &&
            ((wb0_valid && wb0_rd != 5'd0 && !pending[wb0_rd] && !set_mask[wb0_rd]) ||
             (wb1_valid && wb1_rd != 5'd0 && !pending[wb1_rd] && !set_mask[wb1_rd]));

        cnt_nxt = '0;
        for (int i = 1; i < NREG; i++) cnt_nxt = cnt_nxt + 6'(pend_nxt[i]);
    end

    assign hazard0 = pending[q0_rj] | pending[q0_rk] | ((q0_rd_src | q0_we) & pending[q0_rd]);
    assign hazard1 = pending[q1_rj] | pending[q1_rk] | ((q1_rd_src | q1_we) & pending[q1_rd]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            pend_cnt  <= '0;
            wb_orphan <= 1'b0;
        end else begin
            pending   <= pend_nxt;
            pend_cnt  <= cnt_nxt;
            wb_orphan <= wb_orphan | orphan_hit;
        end
    end

`ifdef SCOREBOARD_WATCHDOG_EN
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [AGE_W-1:0] age     [NREG];
    logic [AGE_W-1:0] age_nxt [NREG];
    logic             wd_hit;

    // age only survives while the register stays pending; a fresh set restarts it
    always_comb begin
        wd_hit = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            age_nxt[i] = '0;
            if (!flush && !set_mask[i] && pending[i] && !clr_mask[i])
                age_nxt[i] = (age[i] == AGE_MAX) ? AGE_MAX : age[i] + 1'b1;
            if (age_nxt[i] == AGE_MAX) wd_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) age[i] <= '0;
            wd_timeout <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) age[i] <= age_nxt[i];
            wd_timeout <= !flush && (wd_timeout || wd_hit);
        end
    end
`else
    assign wd_timeout = 1'b0;
`endif

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register scoreboard that tracks destination registers of in-flight multi-cycle operations (mul, div, dcache load, priv/CSR read) across both issue slots. It sits beside the dual-issue dispatcher: it raises per-slot hazard flags that hold back dependent instructions. It records a pending write when a long-latency instruction issues, and releases it when that instruction's writeback port fires.

## Interface
- NREG, 32, architectural register count; r0 is never tracked
- AGE_W, 6, width of per-entry watchdog age counter (only with the watchdog compiled in)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  pipeline flush; clears all pending state
- stall  in  1  issue stage frozen; blocks set, does not block clear
- qN_rj, qN_rk, qN_rd  in  5 each  (N=0,1) query operands of slot N
- qN_rd_src  in  1  slot N reads rd as a source (store/branch style)
- qN_we  in  1  slot N writes rd
- hazardN  out  1  slot N depends on a pending register
- issN_go  in  1  slot N leaves issue this cycle
- issN_rd  in  5  destination of slot N
- issN_long  in  1  slot N is a multi-cycle writer
- wbN_valid  in  1  writeback port N fires
- wbN_rd  in  5  writeback port N destination
- pend_cnt  out  6  number of pending registers (registered)
- wb_orphan  out  1  sticky: writeback to a non-pending register
- wd_timeout  out  1  sticky watchdog flag (0 when compiled out)

## Operation
- State: pending[NREG-1:0]; bit 0 is hardwired 0.
- hazardN = pending[qN_rj] | pending[qN_rk] | (qN_rd_src & pending[qN_rd]) | (qN_we & pending[qN_rd]).
  - The last term is the WAW check.
  - Purely combinational from registered pending; no writeback bypass.
- Set mask: bit issN_rd when issN_go & issN_long & issN_rd!=0 & !stall.
- Clear mask: bit wbN_rd when wbN_valid & wbN_rd!=0.
- Update priority: flush > set > clear.
  - Next pending = flush ? 0 : (pending & ~clear) | set.
- Both slots setting the same rd yields one pending bit; legal.
- wb_orphan sets when wbN_valid, wbN_rd!=0, pending[wbN_rd]==0 and no same-cycle set of that bit. It is cleared only by rst.
- pend_cnt = popcount of next pending, registered with pending.

## Timing
- Reset: pending=0, pend_cnt=0, wb_orphan=0, wd_timeout=0. Therefore hazard0/hazard1=0.
- Set latency: 1 cycle. A register issued at cycle T appears in hazard at T+1.
- Clear latency: 1 cycle. A writeback at T drops the hazard at T+1; a dependent instruction issues at T+1 at the earliest.
- Stall held: sets are suppressed; writebacks still clear; hazard tracks the current pending.
- Flush: takes effect on the next edge. Writebacks in the flush cycle are discarded with the state; no orphan is flagged for them.
- rst asserted mid-operation: all state returns to reset values immediately, independent of clk.

## Configuration
- SCOREBOARD_WATCHDOG_EN defined:
  - Each nonzero register has an AGE_W-bit counter.
  - The counter zeroes on set and increments each cycle while pending, saturating at all-ones.
  - When any counter reaches all-ones, wd_timeout sets, sticky until rst or flush.
  - Flush zeroes all counters.
- Undefined: no counters are instantiated; wd_timeout is tied 0.

## Test plan
- Reset, then iss0_go long rd=5 at T; q1_rj=5: hazard1=0 at T, 1 at T+1; pend_cnt=1.
- wb1_valid rd=5 at T+4: hazard1=0 at T+5, pend_cnt=0; wb_orphan stays 0.
- stall=1 with iss0_go long rd=7 and wb0 rd=5 (pending) in the same cycle: rd7 not pending, rd5 cleared.
- Set rd=3, q0_we rd=3: hazard0=1 (WAW). Slot0 long rd=0: never pending, pend_cnt unchanged.
- Pending {3,9}, flush together with wb rd=3: next cycle pending=0, pend_cnt=0, wb_orphan=0. wb rd=12 alone afterwards: wb_orphan=1.
- With SCOREBOARD_WATCHDOG_EN and AGE_W=4, set rd=6 and never write back: wd_timeout=1 by cycle 16 after set. Without the macro: wd_timeout=0 throughout.
